multisim_stream_downsizer: RTL and testbench
============================================

Name: multisim_stream_downsizer

Overview:
- Sits directly downstream of the multisim pull server and consumes its wide valid/ready word stream.
- Buffers words in a small FIFO so the bursty DPI pull side is decoupled from the consumer.
- Splits each word into RATIO narrow beats, least-significant slice first, with a last flag on the final beat.
- Typical use: a 64-bit DPI word becomes 8 byte-beats into a UART/AXI-Stream model.

Parameters:
- OUT_WIDTH, 8: width of one output beat.
- RATIO, 8: beats per input word, >=1.
- FIFO_DEPTH, 4: input word FIFO entries; power of two, >=2.
- IN_WIDTH, OUT_WIDTH*RATIO: input word width. Derived localparam; not overridable.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- in_vld  input  1  upstream word valid (from pull server data_vld).
- in_rdy  output  1  ready to accept a word (to pull server data_rdy).
- in_data  input  IN_WIDTH  upstream word.
- out_vld  output  1  beat valid.
- out_rdy  input  1  downstream ready.
- out_data  output  OUT_WIDTH  current beat.
- out_last  output  1  high on the final beat of a word.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the word held in the output stage.

Behaviour:
- Reset (rst high at posedge):
  - FIFO emptied, output stage IDLE, beat counter cleared.
  - out_vld=0, out_data=0, out_last=0, fifo_count=0.
  - in_rdy=0 while rst is high.
- Input handshake:
  - in_rdy = !rst && (fifo_count != FIFO_DEPTH). It depends only on registered state; there is no combinational path from out_rdy.
  - A word is written when in_vld && in_rdy at a posedge.
  - A pop and a push in the same cycle leave fifo_count unchanged.
  - When the FIFO is full, in_rdy stays 0 even if a pop occurs that cycle.
- Output stage FSM:
  - IDLE: out_vld=0. If the FIFO is non-empty, pop its head into the word register, set beat=0, go to SEND.
  - SEND: out_vld=1, out_data = word[beat*OUT_WIDTH +: OUT_WIDTH], out_last = (beat==RATIO-1).
    - On out_vld && out_rdy with !out_last: beat increments.
    - On out_vld && out_rdy with out_last: if the FIFO is non-empty, pop the next word in the same cycle, beat=0, stay in SEND (zero bubble). Otherwise go to IDLE.
  - Stall rule: while out_vld && !out_rdy, out_data, out_last and beat hold stable.
- Latency:
  - A word accepted at edge t into an empty FIFO with the stage IDLE is loaded at edge t+1.
  - Its first beat is therefore valid after edge t+1.
  - Steady-state throughput is one beat per cycle.
- RATIO==1: beat is always 0 and out_last is constant 1 whenever out_vld. The block degenerates to a FIFO with one output register.
- Capacity: with out_rdy held low the block holds FIFO_DEPTH+1 words (FIFO plus output register).
- Width and pointers:
  - FIFO read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - The beat counter is max(1,$clog2(RATIO)) bits and must never reach RATIO.
- X handling: in_data may carry X from a 4-state upstream. Control paths never depend on data bits.
- Reset mid-word: remaining beats and all buffered words are discarded. After reset release the next accepted word starts at beat 0.

Decomposition:
- Shared package multisim_stream_pkg:
  - count-width helper function.
  - enum stream_state_e {IDLE, SEND}.
- Sub-module multisim_sync_fifo (DATA_WIDTH, DEPTH; clk, rst, push, pop, wdata, rdata, full, empty, count). Reusable by other multisim stream blocks.
- The downsizer instantiates the FIFO and contains the FSM, beat counter and slice mux.

Test Plan (OUT_WIDTH=8, RATIO=4, FIFO_DEPTH=4 unless noted):
- Single word 32'h44332211 accepted at edge t, out_rdy=1 -> beats 11,22,33,44 on edges t+1..t+4. out_last only on 44. Then out_vld=0.
- Two back-to-back words AABBCCDD, 01020304 with out_rdy=1 -> 8 contiguous beats DD,CC,BB,AA,04,03,02,01 with no idle cycle. out_last on AA and 01.
- out_rdy=0, upstream offers 6 words -> 5 accepted. fifo_count=4, in_rdy=0, out_data=first word beat 0 stable. Raising out_rdy drains all 20 beats in order.
- out_rdy pattern 1,0,0,1,0,1 during a word -> out_data/out_last held during every 0 cycle. No beat lost or duplicated.
- rst pulse for 1 cycle after beat 2 of word 1, FIFO holding 2 words -> next cycle out_vld=0, fifo_count=0, in_rdy=0 during rst. Next word starts at its beat 0.
- RATIO=1, OUT_WIDTH=16: words 0x1234, 0xBEEF -> beats 1234, BEEF, each with out_last=1, one per cycle.

Source files
------------

// File: rtl/multisim_stream_pkg.sv
// Shared types and helpers for the multisim stream blocks.
// Holds the output-stage state encoding and the occupancy-counter width rule.
package multisim_stream_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_e;

    // An occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/multisim_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; DEPTH must be a power of two.
// Pointers wrap naturally, and rdata always shows the current head entry.
module multisim_sync_fifo
    import multisim_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wptr_r;
    logic [PW-1:0]         rptr_r;
    logic [CW-1:0]         count_r;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_r == DEPTH_C);
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;
    assign rdata   = mem_r[rptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (do_push) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (do_pop) begin
                rptr_r <= rptr_r + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_r[wptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/multisim_stream_downsizer.sv
// Wide-to-narrow stream downsizer: buffers input words in a FIFO and emits each
// word as RATIO beats, least-significant slice first, with last on the final beat.
module multisim_stream_downsizer
    import multisim_stream_pkg::*;
#(
    parameter int OUT_WIDTH  = 8,
    parameter int RATIO      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_vld,
    output logic                               in_rdy,
    input  logic [OUT_WIDTH*RATIO-1:0]         in_data,
    output logic                               out_vld,
    input  logic                               out_rdy,
    output logic [OUT_WIDTH-1:0]               out_data,
    output logic                               out_last,
    output logic [count_width(FIFO_DEPTH)-1:0] fifo_count
);

    localparam int IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int BW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    stream_state_e         state_r;
    stream_state_e         state_next;
    logic [BW-1:0]         beat_r;
    logic [BW-1:0]         beat_next;
    logic [IN_WIDTH-1:0]   word_r;
    logic [IN_WIDTH-1:0]   fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  is_last;

    // in_rdy looks only at the registered FIFO count, never at out_rdy.
    assign in_rdy = !rst && !fifo_full;
    assign push   = in_vld && in_rdy;

    multisim_sync_fifo #(
        .DATA_WIDTH (IN_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign is_last = (beat_r == LAST_BEAT);

    // Output-stage next state, beat advance and FIFO pop decision.
    always_comb begin
        state_next = state_r;
        beat_next  = beat_r;
        pop        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    beat_next  = {BW{1'b0}};
                    state_next = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                if (out_rdy) begin
                    if (!is_last) begin
                        beat_next = beat_r + BW'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word without a bubble.
                        pop        = 1'b1;
                        beat_next  = {BW{1'b0}};
                        state_next = SEND;
                    end else begin
                        beat_next  = {BW{1'b0}};
                        state_next = IDLE;
                    end
                end else begin
                    beat_next = beat_r;
                end
            end
            default: begin
                beat_next  = {BW{1'b0}};
                state_next = IDLE;
            end
        endcase
    end

    // Output-stage state, beat counter and held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            beat_r  <= {BW{1'b0}};
            word_r  <= {IN_WIDTH{1'b0}};
        end else begin
            state_r <= state_next;
            beat_r  <= beat_next;
            if (pop) begin
                word_r <= fifo_rdata;
            end else begin
                word_r <= word_r;
            end
        end
    end

    assign out_vld  = (state_r == SEND);
    assign out_last = out_vld && is_last;
    assign out_data = out_vld ? word_r[int'(beat_r) * OUT_WIDTH +: OUT_WIDTH]
                              : {OUT_WIDTH{1'b0}};

endmodule

// File: tb/tb_multisim_stream_downsizer.sv
// Scoreboard bench for multisim_stream_downsizer: a RATIO=4 instance for the main
// plan plus a RATIO=1 / 16-bit instance for the degenerate case.
module tb_multisim_stream_downsizer;

    localparam int OW = 8;
    localparam int R  = 4;
    localparam int D  = 4;
    localparam int IW = OW * R;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_vld, in_rdy, out_vld, out_rdy, out_last;
    logic [IW-1:0] in_data;
    logic [OW-1:0] out_data;
    logic [2:0]    fifo_count;

    logic          in_vld1, in_rdy1, out_vld1, out_rdy1, out_last1;
    logic [15:0]   in_data1, out_data1;
    logic [2:0]    fifo_count1;

    multisim_stream_downsizer #(.OUT_WIDTH(OW), .RATIO(R), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_last(out_last), .fifo_count(fifo_count)
    );

    multisim_stream_downsizer #(.OUT_WIDTH(16), .RATIO(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .in_vld(in_vld1), .in_rdy(in_rdy1), .in_data(in_data1),
        .out_vld(out_vld1), .out_rdy(out_rdy1), .out_data(out_data1),
        .out_last(out_last1), .fifo_count(fifo_count1)
    );

    int checks = 0;
    int passes = 0;

    // Expected beats as {last, data}, pushed when a word is accepted.
    logic [OW:0] exp_q[$];
    logic [16:0] exp1_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Input monitor: the model slices each accepted word into its beats.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp1_q.delete();
        end else begin
            if (in_vld && in_rdy)
                for (int i = 0; i < R; i++)
                    exp_q.push_back({(i == R - 1), in_data[i*OW +: OW]});
            if (in_vld1 && in_rdy1)
                exp1_q.push_back({1'b1, in_data1});
        end
    end

    // Output monitor: every valid beat must equal the queue head; pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got data %0h, required no beat", out_data);
                end else begin
                    check("beat_data", {56'd0, out_data}, {56'd0, exp_q[0][OW-1:0]});
                    check("beat_last", {63'd0, out_last}, {63'd0, exp_q[0][OW]});
                    if (out_rdy) void'(exp_q.pop_front());
                end
            end
            if (out_vld1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat_r1: got data %0h, required no beat", out_data1);
                end else begin
                    check("r1_data", {48'd0, out_data1}, {48'd0, exp1_q[0][15:0]});
                    check("r1_last", {63'd0, out_last1}, {63'd0, exp1_q[0][16]});
                    if (out_rdy1) void'(exp1_q.pop_front());
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        out_rdy = 1'b1;
        while ((exp_q.size() != 0 || out_vld) && n < 300) begin
            cyc();
            n++;
        end
        check({name, "_empty"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check({name, "_idle"}, {63'd0, out_vld}, 64'd0);
    endtask

    int acc, run, maxrun, total;
    bit hs;
    int pat[10] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
        in_vld1 = 1'b0; in_data1 = '0; out_rdy1 = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        check("rst_out_vld", {63'd0, out_vld}, 64'd0);
        check("rst_out_data", {56'd0, out_data}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_fifo_count", {61'd0, fifo_count}, 64'd0);
        check("rst_in_rdy", {63'd0, in_rdy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single word: loaded one edge after acceptance, four beats, then idle.
        out_rdy = 1'b1;
        in_vld = 1'b1; in_data = 32'h44332211;
        cyc();
        in_vld = 1'b0;
        @(negedge clk);
        check("single_latency_vld", {63'd0, out_vld}, 64'd0);
        check("single_fifo_count", {61'd0, fifo_count}, 64'd1);
        cyc();
        @(negedge clk);
        check("single_first_vld", {63'd0, out_vld}, 64'd1);
        repeat (4) cyc();
        @(negedge clk);
        check("single_done_vld", {63'd0, out_vld}, 64'd0);

        // Back-to-back words must produce 8 contiguous beats.
        in_vld = 1'b1; in_data = 32'hAABBCCDD;
        cyc();
        in_data = 32'h01020304;
        cyc();
        in_vld = 1'b0;
        run = 0; maxrun = 0; total = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_vld) begin run++; total++; end else run = 0;
            if (run > maxrun) maxrun = run;
            cyc();
        end
        check("b2b_total", 64'(total), 64'd8);
        check("b2b_contiguous", 64'(maxrun), 64'd8);

        // Stalled consumer: capacity is FIFO_DEPTH+1 words.
        out_rdy = 1'b0; acc = 0;
        in_vld = 1'b1; in_data = $urandom;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            hs = in_vld && in_rdy;
            if (hs) acc++;
            cyc();
            if (hs) in_data = $urandom;
            if (acc == 6) in_vld = 1'b0;
        end
        in_vld = 1'b0;
        @(negedge clk);
        check("full_accepted", 64'(acc), 64'd5);
        check("full_fifo_count", {61'd0, fifo_count}, 64'd4);
        check("full_in_rdy", {63'd0, in_rdy}, 64'd0);
        check("full_out_vld", {63'd0, out_vld}, 64'd1);
        cyc();
        drain("full_drain");

        // Irregular out_rdy during a word: beats must hold while stalled.
        out_rdy = 1'b0;
        in_vld = 1'b1; in_data = $urandom;
        cyc();
        in_vld = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) begin
            out_rdy = pat[i][0];
            cyc();
        end
        drain("stall_drain");

        // Reset mid-word with two words still buffered.
        out_rdy = 1'b0; in_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            cyc();
        end
        in_vld = 1'b0;
        cyc();
        @(negedge clk);
        check("midrst_pre_count", {61'd0, fifo_count}, 64'd2);
        out_rdy = 1'b1;
        cyc(); cyc();
        out_rdy = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("midrst_in_rdy", {63'd0, in_rdy}, 64'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_vld", {63'd0, out_vld}, 64'd0);
        check("midrst_fifo_count", {61'd0, fifo_count}, 64'd0);
        check("midrst_in_rdy_after", {63'd0, in_rdy}, 64'd1);
        cyc();
        out_rdy = 1'b1; in_vld = 1'b1; in_data = 32'hDEADBEEF;
        cyc();
        in_vld = 1'b0;
        drain("midrst_drain");

        // RATIO=1 instance: one beat per word, one per cycle, always last.
        in_vld1 = 1'b1; in_data1 = 16'h1234;
        cyc();
        in_data1 = 16'hBEEF;
        cyc();
        in_vld1 = 1'b0;
        @(negedge clk);
        check("r1_vld_first", {63'd0, out_vld1}, 64'd1);
        cyc();
        @(negedge clk);
        check("r1_vld_second", {63'd0, out_vld1}, 64'd1);
        cyc();
        @(negedge clk);
        check("r1_vld_done", {63'd0, out_vld1}, 64'd0);
        check("r1_queue_empty", 64'(exp1_q.size()), 64'd0);

        // Randomized traffic on both instances.
        for (int c = 0; c < 1500; c++) begin
            in_vld   = ($urandom_range(0, 1) == 1);
            in_data  = $urandom;
            out_rdy  = ($urandom_range(0, 3) != 0);
            in_vld1  = ($urandom_range(0, 1) == 1);
            in_data1 = 16'($urandom);
            out_rdy1 = ($urandom_range(0, 2) != 0);
            cyc();
        end
        in_vld = 1'b0; in_vld1 = 1'b0; out_rdy1 = 1'b1;
        drain("rand_drain");
        repeat (10) cyc();
        check("rand_r1_empty", 64'(exp1_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
